mining_nonce_sweeper: RTL and testbench

Parametrised mining controller that owns a multi-chunk message buffer, inserts a sweeping nonce at a programmable bit position, and streams 512-bit chunks to the external SHA-256 chunk core. It compares each returned 256-bit hash against a leading-zero difficulty and stops on the first hit, on range exhaustion, or on abort. It replaces the fixed two-chunk, fixed-nonce loading flow. It sits between the host/test loader and the chunk hashing core.

---
 rtl/mining_nonce_sweeper_if.sv | 50 +++++
 rtl/mining_nonce_sweeper.sv | 180 ++++++++++++++++++
 tb/tb_mining_nonce_sweeper.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mining_nonce_sweeper_if.sv
// Host/core-facing bundle of the nonce sweeper: buffer loader, sweep config,
// chunk stream to the SHA-256 core, digest return and status.
interface mining_nonce_sweeper_if #(
    parameter int MAX_CHUNKS = 4,
    parameter int NONCE_W    = 32
);
    localparam int AW = $clog2(MAX_CHUNKS);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [511:0]       wr_data;
    logic [AW:0]        num_chunks;
    logic [AW-1:0]      nonce_chunk;
    logic [8:0]         nonce_bit;
    logic [NONCE_W-1:0] nonce_start;
    logic [NONCE_W-1:0] nonce_end;
    logic [8:0]         difficulty;
    logic               start;
    logic               abort;
    logic [511:0]       chunk;
    logic               chunk_valid;
    logic               chunk_ready;
    logic               chunk_first;
    logic               chunk_last;
    logic [255:0]       hash_in;
    logic               hash_valid;
    logic               busy;
    logic               found;
    logic               exhausted;
    logic               error;
    logic [NONCE_W-1:0] nonce_out;
    logic [255:0]       hash_out;
    logic [31:0]        attempts;

    modport master (
        output wr_en, wr_addr, wr_data, num_chunks, nonce_chunk, nonce_bit,
               nonce_start, nonce_end, difficulty, start, abort, chunk_ready,
               hash_in, hash_valid,
        input  chunk, chunk_valid, chunk_first, chunk_last, busy, found,
               exhausted, error, nonce_out, hash_out, attempts
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, num_chunks, nonce_chunk, nonce_bit,
               nonce_start, nonce_end, difficulty, start, abort, chunk_ready,
               hash_in, hash_valid,
        output chunk, chunk_valid, chunk_first, chunk_last, busy, found,
               exhausted, error, nonce_out, hash_out, attempts
    );
endinterface

// File: rtl/mining_nonce_sweeper.sv
// Mining controller: streams buffered chunks with a sweeping nonce inserted and
// stops on the first digest meeting the leading-zero difficulty.
module mining_nonce_sweeper #(
    parameter int MAX_CHUNKS = 4,
    parameter int NONCE_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    mining_nonce_sweeper_if.slave bus
);
    localparam int AW = $clog2(MAX_CHUNKS);

    typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT, CMP} state_t;

    state_t             state_q, state_d;
    logic [511:0]       buffer_q [MAX_CHUNKS];
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        numChunks_q, numChunks_d;
    logic [AW-1:0]      nonceChunk_q, nonceChunk_d;
    logic [8:0]         nonceBit_q, nonceBit_d;
    logic [NONCE_W-1:0] nonceEnd_q, nonceEnd_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [8:0]         difficulty_q, difficulty_d;
    logic [255:0]       hash_q, hash_d;
    logic [31:0]        attempts_q, attempts_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               error_q, error_d;

    logic               configBad;
    logic               isLast;
    logic [511:0]       insMask;
    logic [511:0]       insData;
    logic [511:0]       chunkData;

    function automatic logic [8:0] leadingZeros(input logic [255:0] h);
        logic [8:0] n;
        n = 9'd256;
        for (int i = 0; i < 256; i++) begin
            if (h[i]) n = 9'(255 - i);
        end
        return n;
    endfunction

    // Message buffer is deliberately left out of reset; only the host loads it.
    always_ff @(posedge clock) begin
        if (bus.wr_en && state_q == IDLE) buffer_q[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        configBad = (numChunks_q == '0)
                 || (numChunks_q > (AW+1)'(MAX_CHUNKS))
                 || ((AW+1)'(nonceChunk_q) >= numChunks_q)
                 || ((10'(nonceBit_q) + 10'(NONCE_W)) > 10'd512)
                 || (difficulty_q > 9'd256);
        isLast    = ({1'b0, idx_q} == (numChunks_q - (AW+1)'(1)));
        insMask   = {{(512-NONCE_W){1'b0}}, {NONCE_W{1'b1}}} << nonceBit_q;
        insData   = {{(512-NONCE_W){1'b0}}, nonce_q} << nonceBit_q;
        chunkData = buffer_q[idx_q];
        if (idx_q == nonceChunk_q) chunkData = (chunkData & ~insMask) | insData;
    end

    // Abort overrides every transition; a handshake in that cycle does not count.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        numChunks_d  = numChunks_q;
        nonceChunk_d = nonceChunk_q;
        nonceBit_d   = nonceBit_q;
        nonceEnd_d   = nonceEnd_q;
        nonce_d      = nonce_q;
        difficulty_d = difficulty_q;
        hash_d       = hash_q;
        attempts_d   = attempts_q;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        error_d      = error_q;
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d      = CHECK;
                        found_d      = 1'b0;
                        exhausted_d  = 1'b0;
                        error_d      = 1'b0;
                        attempts_d   = '0;
                        nonce_d      = bus.nonce_start;
                        idx_d        = '0;
                        numChunks_d  = bus.num_chunks;
                        nonceChunk_d = bus.nonce_chunk;
                        nonceBit_d   = bus.nonce_bit;
                        nonceEnd_d   = bus.nonce_end;
                        difficulty_d = bus.difficulty;
                    end
                end
                CHECK: begin
                    if (configBad) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (bus.chunk_ready) begin
                        if (isLast) state_d = WAIT;
                        else        idx_d   = idx_q + AW'(1);
                    end
                end
                WAIT: begin
                    if (bus.hash_valid) begin
                        hash_d  = bus.hash_in;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    attempts_d = (attempts_q == '1) ? attempts_q : attempts_q + 32'd1;
                    if (leadingZeros(hash_q) >= difficulty_q) begin
                        found_d = 1'b1;
                        state_d = IDLE;
                    end else if (nonce_q == nonceEnd_q) begin
                        exhausted_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        nonce_d = nonce_q + NONCE_W'(1);
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            numChunks_q  <= '0;
            nonceChunk_q <= '0;
            nonceBit_q   <= '0;
            nonceEnd_q   <= '0;
            nonce_q      <= '0;
            difficulty_q <= '0;
            hash_q       <= '0;
            attempts_q   <= '0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            numChunks_q  <= numChunks_d;
            nonceChunk_q <= nonceChunk_d;
            nonceBit_q   <= nonceBit_d;
            nonceEnd_q   <= nonceEnd_d;
            nonce_q      <= nonce_d;
            difficulty_q <= difficulty_d;
            hash_q       <= hash_d;
            attempts_q   <= attempts_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            error_q      <= error_d;
        end
    end

    assign bus.chunk_valid = (state_q == SEND);
    assign bus.chunk       = (state_q == SEND) ? chunkData : '0;
    assign bus.chunk_first = (state_q == SEND) && (idx_q == '0);
    assign bus.chunk_last  = (state_q == SEND) && isLast;
    assign bus.busy        = (state_q != IDLE);
    assign bus.found       = found_q;
    assign bus.exhausted   = exhausted_q;
    assign bus.error       = error_q;
    assign bus.nonce_out   = nonce_q;
    assign bus.hash_out    = hash_q;
    assign bus.attempts    = attempts_q;
endmodule

// File: tb/tb_mining_nonce_sweeper.sv
// Bench for mining_nonce_sweeper: a toy chunk core that "hits" on one nonce,
// plus a sweep-sequence reference model, on a 32-bit and a 4-bit nonce instance.
module tb_mining_nonce_sweeper;
    localparam logic [255:0] HIT  = {8'h00, {248{1'b1}}};
    localparam logic [255:0] MISS = {8'h01, {248{1'b1}}};

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    mining_nonce_sweeper_if #(.MAX_CHUNKS(4), .NONCE_W(32)) ifA ();
    mining_nonce_sweeper_if #(.MAX_CHUNKS(4), .NONCE_W(4))  ifB ();

    mining_nonce_sweeper #(.MAX_CHUNKS(4), .NONCE_W(32)) dutA (.clock(clock), .reset(reset), .bus(ifA.slave));
    mining_nonce_sweeper #(.MAX_CHUNKS(4), .NONCE_W(4))  dutB (.clock(clock), .reset(reset), .bus(ifB.slave));

    logic [511:0] memA [4];
    logic [511:0] memB [4];
    logic [511:0] accA [$];
    logic [1:0]   accFlagsA [$];
    logic [511:0] expA [$];
    logic [1:0]   expFlagsA [$];
    logic [511:0] accB [$];
    int           nonceBitA = 0, nonceChunkA = 1, cntA = 0, trkA = 0;
    int           nonceBitB = 0, nonceChunkB = 1, cntB = 0, trkB = 0;
    logic [31:0]  hitNonceA = 32'd7, curA = '0;
    logic [3:0]   hitNonceB = 4'd7,  curB = '0;
    logic         pendA = 1'b0, pendB = 1'b0;

    // Toy SHA core: answers 3 cycles after the last chunk of a message is taken.
    always @(negedge clock) begin : coreA
        ifA.hash_valid = 1'b0;
        if (!reset) begin
            cntA = 0;
            trkA = 0;
            ifA.hash_in = '0;
        end else begin
            if (cntA > 0) begin
                cntA--;
                if (cntA == 0) begin
                    ifA.hash_valid = 1'b1;
                    ifA.hash_in    = pendA ? HIT : MISS;
                end
            end
            if (ifA.chunk_valid && ifA.chunk_ready && !ifA.abort) begin
                accA.push_back(ifA.chunk);
                accFlagsA.push_back({ifA.chunk_first, ifA.chunk_last});
                trkA = ifA.chunk_first ? 0 : trkA + 1;
                if (trkA == nonceChunkA) curA = 32'(ifA.chunk >> nonceBitA);
                if (ifA.chunk_last) begin
                    cntA  = 3;
                    pendA = (curA == hitNonceA);
                end
            end
        end
    end

    always @(negedge clock) begin : coreB
        ifB.hash_valid = 1'b0;
        if (!reset) begin
            cntB = 0;
            trkB = 0;
            ifB.hash_in = '0;
        end else begin
            if (cntB > 0) begin
                cntB--;
                if (cntB == 0) begin
                    ifB.hash_valid = 1'b1;
                    ifB.hash_in    = pendB ? HIT : MISS;
                end
            end
            if (ifB.chunk_valid && ifB.chunk_ready && !ifB.abort) begin
                accB.push_back(ifB.chunk);
                trkB = ifB.chunk_first ? 0 : trkB + 1;
                if (trkB == nonceChunkB) curB = 4'(ifB.chunk >> nonceBitB);
                if (ifB.chunk_last) begin
                    cntB  = 3;
                    pendB = (curB == hitNonceB);
                end
            end
        end
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] withNonce(input logic [511:0] b, input logic [63:0] n,
                                               input int pos, input int w);
        logic [511:0] r;
        r = b;
        for (int i = 0; i < w; i++) r[pos + i] = n[i];
        return r;
    endfunction

    // Expected chunk stream: every attempt replays the whole message with its own nonce.
    function automatic void buildExpA(input logic [31:0] ns, input int att, input int nc,
                                      input int nch, input int nb);
        logic [31:0] n;
        expA.delete();
        expFlagsA.delete();
        for (int a = 0; a < att; a++) begin
            n = ns + 32'(a);
            for (int c = 0; c < nc; c++) begin
                expA.push_back((c == nch) ? withNonce(memA[c], 64'(n), nb, 32) : memA[c]);
                expFlagsA.push_back({c == 0, c == nc - 1});
            end
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic loadA();
        for (int c = 0; c < 4; c++) begin
            memA[c]     = rand512();
            ifA.wr_addr = 2'(c);
            ifA.wr_data = memA[c];
            ifA.wr_en   = 1'b1;
            tick();
        end
        ifA.wr_en = 1'b0;
    endtask

    task automatic loadB();
        for (int c = 0; c < 4; c++) begin
            memB[c]     = rand512();
            ifB.wr_addr = 2'(c);
            ifB.wr_data = memB[c];
            ifB.wr_en   = 1'b1;
            tick();
        end
        ifB.wr_en = 1'b0;
    endtask

    task automatic startA(input int nc, input int nch, input int nb,
                          input logic [31:0] ns, input logic [31:0] ne, input int diff);
        ifA.num_chunks  = 3'(nc);
        ifA.nonce_chunk = 2'(nch);
        ifA.nonce_bit   = 9'(nb);
        ifA.nonce_start = ns;
        ifA.nonce_end   = ne;
        ifA.difficulty  = 9'(diff);
        nonceBitA   = nb;
        nonceChunkA = nch;
        accA.delete();
        accFlagsA.delete();
        ifA.start = 1'b1;
        tick();
        ifA.start = 1'b0;
    endtask

    task automatic startB(input int nc, input int nch, input int nb,
                          input logic [3:0] ns, input logic [3:0] ne, input int diff);
        ifB.num_chunks  = 3'(nc);
        ifB.nonce_chunk = 2'(nch);
        ifB.nonce_bit   = 9'(nb);
        ifB.nonce_start = ns;
        ifB.nonce_end   = ne;
        ifB.difficulty  = 9'(diff);
        nonceBitB   = nb;
        nonceChunkB = nch;
        accB.delete();
        ifB.start = 1'b1;
        tick();
        ifB.start = 1'b0;
    endtask

    task automatic waitIdleA(input int budget, input bit randReady, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (!ifA.busy) break;
            n++;
            if (n > budget) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: timeout, busy=%0b required 0", name, ifA.busy);
                break;
            end
            @(posedge clock);
            #1;
            if (randReady) ifA.chunk_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
    endtask

    task automatic waitIdleB(input int budget, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clock);
            if (!ifB.busy) break;
            n++;
            if (n > budget) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: timeout, busy=%0b required 0", name, ifB.busy);
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if ({ifA.busy, ifA.found, ifA.exhausted, ifA.error, ifA.chunk_valid, ifA.chunk_first, ifA.chunk_last} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b required 0000000",
                     {ifA.busy, ifA.found, ifA.exhausted, ifA.error, ifA.chunk_valid, ifA.chunk_first, ifA.chunk_last});
        end
        total++;
        if (ifA.nonce_out !== 32'd0 || ifA.attempts !== 32'd0 || ifA.hash_out !== 256'd0 || ifA.chunk !== 512'd0) begin
            bad++;
            $display("[TB] FAIL reset_values: nonce=%0h attempts=%0d hash_lo=%0h chunk_lo=%0h required all 0",
                     ifA.nonce_out, ifA.attempts, ifA.hash_out[31:0], ifA.chunk[31:0]);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        loadA();
        hitNonceA = 32'd7;
        ifA.chunk_ready = 1'b1;
        startA(2, 1, 0, 32'd5, 32'd9, 8);
        @(negedge clock);
        total++;
        if (ifA.chunk_valid !== 1'b0 || ifA.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hit_check_cycle: valid=%0b busy=%0b required 0 1", ifA.chunk_valid, ifA.busy);
        end
        @(negedge clock);
        total++;
        if (ifA.chunk_valid !== 1'b1 || ifA.chunk_first !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hit_first_valid: valid=%0b first=%0b required 1 1", ifA.chunk_valid, ifA.chunk_first);
        end
        waitIdleA(200, 1'b0, "hit_wait");
        total++;
        if (ifA.found !== 1'b1 || ifA.exhausted !== 1'b0 || ifA.nonce_out !== 32'd7 || ifA.attempts !== 32'd3) begin
            bad++;
            $display("[TB] FAIL hit_result: found=%0b exh=%0b nonce=%0d attempts=%0d required 1 0 7 3",
                     ifA.found, ifA.exhausted, ifA.nonce_out, ifA.attempts);
        end
        total++;
        if (ifA.hash_out !== HIT) begin
            bad++;
            $display("[TB] FAIL hit_hash: got top byte %0h required 00", ifA.hash_out[255:248]);
        end
        buildExpA(32'd5, 3, 2, 1, 0);
        total++;
        if (accA.size() != expA.size()) begin
            bad++;
            $display("[TB] FAIL hit_transfers: got %0d required %0d", accA.size(), expA.size());
        end
        for (int i = 0; i < accA.size() && i < expA.size(); i++) begin
            total++;
            if (accA[i] !== expA[i] || accFlagsA[i] !== expFlagsA[i]) begin
                bad++;
                $display("[TB] FAIL hit_chunk%0d: got lo=%0h flags=%b required lo=%0h flags=%b",
                         i, accA[i][63:0], accFlagsA[i], expA[i][63:0], expFlagsA[i]);
            end
        end
    endtask

    task automatic test_exhaust();
        hitNonceA = 32'd7;
        ifA.chunk_ready = 1'b1;
        startA(2, 1, 0, 32'd5, 32'd9, 9);
        waitIdleA(300, 1'b0, "exhaust_wait");
        total++;
        if (ifA.exhausted !== 1'b1 || ifA.found !== 1'b0 || ifA.nonce_out !== 32'd9 || ifA.attempts !== 32'd5) begin
            bad++;
            $display("[TB] FAIL exhaust_result: exh=%0b found=%0b nonce=%0d attempts=%0d required 1 0 9 5",
                     ifA.exhausted, ifA.found, ifA.nonce_out, ifA.attempts);
        end
        total++;
        if (ifA.hash_out !== MISS) begin
            bad++;
            $display("[TB] FAIL exhaust_hash: got top byte %0h required 01", ifA.hash_out[255:248]);
        end
        buildExpA(32'd5, 5, 2, 1, 0);
        total++;
        if (accA.size() != expA.size()) begin
            bad++;
            $display("[TB] FAIL exhaust_transfers: got %0d required %0d", accA.size(), expA.size());
        end
        for (int i = 0; i < accA.size() && i < expA.size(); i++) begin
            total++;
            if (accA[i] !== expA[i] || accFlagsA[i] !== expFlagsA[i]) begin
                bad++;
                $display("[TB] FAIL exhaust_chunk%0d: got lo=%0h required lo=%0h", i, accA[i][63:0], expA[i][63:0]);
            end
        end
    endtask

    task automatic test_stall_abort();
        hitNonceA = 32'd5;
        ifA.chunk_ready = 1'b0;
        startA(2, 1, 0, 32'd5, 32'd9, 8);
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ifA.chunk_valid !== 1'b1 || ifA.chunk_first !== 1'b1 || ifA.chunk !== memA[0]) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d: valid=%0b first=%0b lo=%0h required 1 1 lo=%0h",
                         i, ifA.chunk_valid, ifA.chunk_first, ifA.chunk[63:0], memA[0][63:0]);
            end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        ifA.chunk_ready = 1'b1;
        tick();
        tick();
        ifA.chunk_ready = 1'b0;
        ifA.abort = 1'b1;
        tick();
        ifA.abort = 1'b0;
        @(negedge clock);
        total++;
        if (ifA.busy !== 1'b0 || ifA.found !== 1'b0 || ifA.exhausted !== 1'b0 || ifA.error !== 1'b0 || ifA.chunk_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_idle: busy=%0b found=%0b exh=%0b err=%0b valid=%0b required all 0",
                     ifA.busy, ifA.found, ifA.exhausted, ifA.error, ifA.chunk_valid);
        end
        total++;
        if (ifA.nonce_out !== 32'd5 || ifA.attempts !== 32'd0 || accA.size() != 2) begin
            bad++;
            $display("[TB] FAIL abort_retain: nonce=%0d attempts=%0d transfers=%0d required 5 0 2",
                     ifA.nonce_out, ifA.attempts, accA.size());
        end
        repeat (6) tick();
        total++;
        if (ifA.hash_out !== MISS || ifA.attempts !== 32'd0 || ifA.busy !== 1'b0 || ifA.found !== 1'b0) begin
            bad++;
            $display("[TB] FAIL late_hash_ignored: top=%0h attempts=%0d busy=%0b found=%0b required 01 0 0 0",
                     ifA.hash_out[255:248], ifA.attempts, ifA.busy, ifA.found);
        end
    endtask

    task automatic test_error();
        int cfg [5][4] = '{'{2, 1, 500, 8}, '{0, 0, 0, 8}, '{5, 0, 0, 8}, '{2, 2, 0, 8}, '{2, 1, 0, 257}};
        ifA.chunk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            startA(cfg[k][0], cfg[k][1], cfg[k][2], 32'd0, 32'd3, cfg[k][3]);
            @(negedge clock);
            total++;
            if (ifA.error !== 1'b0 || ifA.busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL error%0d_check_cycle: err=%0b busy=%0b required 0 1", k, ifA.error, ifA.busy);
            end
            @(negedge clock);
            total++;
            if (ifA.error !== 1'b1 || ifA.busy !== 1'b0 || ifA.chunk_valid !== 1'b0 || accA.size() != 0) begin
                bad++;
                $display("[TB] FAIL error%0d_flag: err=%0b busy=%0b valid=%0b transfers=%0d required 1 0 0 0",
                         k, ifA.error, ifA.busy, ifA.chunk_valid, accA.size());
            end
            tick();
        end
        startA(4, 3, 480, 32'd0, 32'd3, 256);
        @(negedge clock);
        @(negedge clock);
        total++;
        if (ifA.chunk_valid !== 1'b1 || ifA.error !== 1'b0) begin
            bad++;
            $display("[TB] FAIL edge_config_ok: valid=%0b err=%0b required 1 0", ifA.chunk_valid, ifA.error);
        end
        @(posedge clock);
        #1;
        ifA.abort = 1'b1;
        tick();
        ifA.abort = 1'b0;
        @(negedge clock);
        total++;
        if (ifA.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL edge_abort: busy=%0b required 0", ifA.busy);
        end
        tick();
    endtask

    task automatic test_wrap();
        loadB();
        hitNonceB = 4'd7;
        ifB.chunk_ready = 1'b1;
        startB(2, 1, 100, 4'd14, 4'd1, 8);
        waitIdleB(300, "wrap_wait");
        total++;
        if (ifB.exhausted !== 1'b1 || ifB.found !== 1'b0 || ifB.nonce_out !== 4'd1 || ifB.attempts !== 32'd4) begin
            bad++;
            $display("[TB] FAIL wrap_result: exh=%0b found=%0b nonce=%0d attempts=%0d required 1 0 1 4",
                     ifB.exhausted, ifB.found, ifB.nonce_out, ifB.attempts);
        end
        total++;
        if (accB.size() != 8) begin
            bad++;
            $display("[TB] FAIL wrap_transfers: got %0d required 8", accB.size());
        end
        for (int k = 0; k < 4 && 2*k+1 < accB.size(); k++) begin
            logic [3:0] expN;
            expN = 4'(14 + k);
            total++;
            if (accB[2*k+1] !== withNonce(memB[1], 64'(expN), 100, 4)) begin
                bad++;
                $display("[TB] FAIL wrap_nonce%0d: got %0d required %0d", k, accB[2*k+1][103:100], expN);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int nc, nch, nb, len, diff, expAtt;
            logic [31:0] ns, ne, n, expNonce;
            logic expFound;
            loadA();
            nc   = $urandom_range(1, 4);
            nch  = $urandom_range(0, nc - 1);
            nb   = $urandom_range(0, 480);
            ns   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            len  = $urandom_range(0, 4);
            ne   = ns + 32'(len);
            diff = ($urandom_range(0, 4) == 0) ? 0 : 8;
            hitNonceA = ($urandom_range(0, 1) == 1) ? ns + 32'($urandom_range(0, len)) : ns + 32'(len + 1);
            expFound = 1'b0;
            expAtt   = len + 1;
            for (int k = 0; k <= len; k++) begin
                n = ns + 32'(k);
                if (diff == 0 || n == hitNonceA) begin
                    expFound = 1'b1;
                    expAtt   = k + 1;
                    break;
                end
            end
            expNonce = ns + 32'(expAtt - 1);
            startA(nc, nch, nb, ns, ne, diff);
            waitIdleA(600, 1'b1, "rand_wait");
            total++;
            if (ifA.found !== expFound || ifA.exhausted !== !expFound || ifA.attempts !== 32'(expAtt) || ifA.nonce_out !== expNonce) begin
                bad++;
                $display("[TB] FAIL rand%0d_result: found=%0b exh=%0b attempts=%0d nonce=%0h required %0b %0b %0d %0h",
                         it, ifA.found, ifA.exhausted, ifA.attempts, ifA.nonce_out, expFound, !expFound, expAtt, expNonce);
            end
            total++;
            if (ifA.hash_out !== ((expNonce == hitNonceA) ? HIT : MISS)) begin
                bad++;
                $display("[TB] FAIL rand%0d_hash: got top byte %0h", it, ifA.hash_out[255:248]);
            end
            buildExpA(ns, expAtt, nc, nch, nb);
            total++;
            if (accA.size() != expA.size()) begin
                bad++;
                $display("[TB] FAIL rand%0d_transfers: got %0d required %0d", it, accA.size(), expA.size());
            end
            for (int i = 0; i < accA.size() && i < expA.size(); i++) begin
                total++;
                if (accA[i] !== expA[i] || accFlagsA[i] !== expFlagsA[i]) begin
                    bad++;
                    $display("[TB] FAIL rand%0d_chunk%0d: flags=%b required %b, data differs=%0b",
                             it, i, accFlagsA[i], expFlagsA[i], accA[i] !== expA[i]);
                end
            end
        end
        ifA.chunk_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        hitNonceA = 32'd7;
        ifA.chunk_ready = 1'b0;
        startA(2, 1, 0, 32'd5, 32'd9, 8);
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (ifA.chunk_valid !== 1'b0 || ifA.busy !== 1'b0 || ifA.chunk !== 512'd0 || ifA.nonce_out !== 32'd0 || ifA.attempts !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid: valid=%0b busy=%0b chunk_lo=%0h nonce=%0d attempts=%0d required all 0",
                     ifA.chunk_valid, ifA.busy, ifA.chunk[31:0], ifA.nonce_out, ifA.attempts);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        ifA.chunk_ready = 1'b1;
        startA(2, 1, 0, 32'd5, 32'd9, 8);
        waitIdleA(200, 1'b0, "rerun_wait");
        total++;
        if (ifA.found !== 1'b1 || ifA.nonce_out !== 32'd7 || ifA.attempts !== 32'd3 || accA.size() != 6) begin
            bad++;
            $display("[TB] FAIL rerun_result: found=%0b nonce=%0d attempts=%0d transfers=%0d required 1 7 3 6",
                     ifA.found, ifA.nonce_out, ifA.attempts, accA.size());
        end
    endtask

    initial begin
        ifA.wr_en = 1'b0; ifA.wr_addr = '0; ifA.wr_data = '0; ifA.num_chunks = '0;
        ifA.nonce_chunk = '0; ifA.nonce_bit = '0; ifA.nonce_start = '0; ifA.nonce_end = '0;
        ifA.difficulty = '0; ifA.start = 1'b0; ifA.abort = 1'b0; ifA.chunk_ready = 1'b0;
        ifB.wr_en = 1'b0; ifB.wr_addr = '0; ifB.wr_data = '0; ifB.num_chunks = '0;
        ifB.nonce_chunk = '0; ifB.nonce_bit = '0; ifB.nonce_start = '0; ifB.nonce_end = '0;
        ifB.difficulty = '0; ifB.start = 1'b0; ifB.abort = 1'b0; ifB.chunk_ready = 1'b0;
        test_reset();
        test_hit();
        test_exhaust();
        test_stall_abort();
        test_error();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
